clarvi_chunked_alu: RTL and testbench
=====================================

Name: clarvi_chunked_alu

Overview:
- Multi-cycle integer ALU for the clarvi datapath.
- Executes operations on operands of PARTS*CHUNK_W bits using a single CHUNK_W-bit datapath, one chunk per cycle.
- Carries carry, compare and shift state between chunks.
- Generalises the fixed two-part 64-on-32 scheme to any part count, adds valid/ready handshaking on both sides, and adds flush.

Parameters:
- CHUNK_W, 32, width of the arithmetic datapath in bits.
- PARTS, 2, number of chunks per full-width operand. Legal range 1..8. Operand width XLEN = CHUNK_W*PARTS.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the current operation.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  4  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. 10-15 reserved.
- in_word  input  1  word op: operate on chunk 0 only, then sign-extend the result.
- in_a  input  XLEN  operand A.
- in_b  input  XLEN  operand B, or shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  XLEN  result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, out_result=0.
  - Chunk counter, carry, lt and eq flags all cleared.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op, word, a, b. Go to EXEC with idx set per the chunk-order rules below.
  - EXEC: in_ready=0. Each cycle computes one CHUNK_W-bit result chunk and writes it into the result register. Go to DONE after the last chunk.
  - DONE: out_valid=1, out_result stable. Go to IDLE when out_ready=1.
- Latency:
  - out_valid rises exactly PARTS rising edges after the accepting edge.
  - Word ops take exactly 1 edge.
  - No back-to-back accept: in_ready is 0 in EXEC and DONE, so throughput is one op per PARTS+2 cycles minimum.
- Chunk order:
  - ADD, SUB, SLL, XOR, OR, AND: LSB-first, idx 0..PARTS-1.
  - SLT, SLTU, SRL, SRA: MSB-first, idx PARTS-1..0.
- ADD/SUB:
  - Per-chunk add of a_i and b_i (SUB uses ~b_i) plus carry-in. Carry-in for chunk 0 is 0 for ADD, 1 for SUB.
  - Carry-out is registered for the next chunk. Final carry is discarded (wrap-around modulo 2^XLEN).
- SLT/SLTU:
  - Scanning MSB-first, keep flags eq (initially 1) and lt (initially 0).
  - Each chunk: if eq and the chunks differ, set lt to the chunk compare and clear eq.
  - The top chunk is compared signed for SLT; all other chunks unsigned.
  - Result is lt in bit 0, all other bits 0. All result chunks other than 0 are written 0.
- Shifts:
  - Shift amount sh = b[log2(XLEN)-1:0]; word ops use b[log2(CHUNK_W)-1:0].
  - Let k = sh / CHUNK_W and r = sh % CHUNK_W.
  - Result chunk j is a CHUNK_W-bit funnel of source chunks j-k and j-k-1 (SLL), or j+k and j+k+1 (SRL/SRA).
  - Out-of-range chunks read as 0 (SLL/SRL) or the sign fill (SRA).
  - No XLEN-wide barrel shifter is permitted.
- Logic ops (XOR/OR/AND): bitwise per chunk.
- Reserved opcodes: sequenced normally, result all-zero.
- Word ops:
  - Compute chunk 0 only, using a[CHUNK_W-1:0] and b[CHUNK_W-1:0].
  - SRA word uses bit CHUNK_W-1 as sign.
  - Upper chunks are filled with result bit CHUNK_W-1.
  - SLT/SLTU word ops compare chunk 0 only (signed for SLT), with the upper result bits 0.
  - When PARTS=1, in_word is ignored.
- flush:
  - When flush=1, state returns to IDLE next edge, out_valid=0, and any in-flight or unconsumed result is discarded.
  - In IDLE, flush has priority over an accept: a request presented with flush=1 is not accepted.
- Async reset asserted mid-EXEC or in DONE: immediately forces the reset values, and no result is produced.
- Input signals are not sampled outside the accept edge. Changes to in_a/in_b during EXEC have no effect.

Test Plan:
- CHUNK_W=32, PARTS=2, ADD a=0x00000000_FFFFFFFF, b=1 -> out_result=0x00000001_00000000, out_valid exactly 2 edges after accept. Then a=0xFFFFFFFF_FFFFFFFF, b=1 -> 0 (wrap).
- PARTS=2, SLT a=0xFFFFFFFF_00000000 (negative), b=0x00000000_00000001 -> result 1. SLTU on the same operands -> 0. Equal operands -> 0 for both.
- PARTS=4, CHUNK_W=16, SRA a=0x8000_0000_0000_1234, b=20 -> 0xFFFF_F800_0000_0000. SLL a=1, b=63 -> 0x8000_0000_0000_0000. SRL b=0 -> unchanged.
- PARTS=2, word ADD a=0x0_7FFFFFFF, b=1 -> 0xFFFFFFFF_80000000, out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result stable, in_ready=0, in_valid ignored. After out_ready=1 -> IDLE, next request accepted.
- Flush asserted during the second EXEC cycle -> no out_valid, in_ready=1 next cycle. Async reset low in DONE -> out_valid=0 and out_result=0 immediately.

Source files
------------

// File: rtl/clarvi_chunked_alu.sv
// Multi-cycle integer ALU: PARTS*CHUNK_W-bit operands processed one CHUNK_W-bit chunk per cycle,
// with carry/compare state carried between chunks, valid/ready handshakes and flush.
module clarvi_chunked_alu #(
    parameter int unsigned CHUNK_W = 32,
    parameter int unsigned PARTS   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic                       in_word,
    input  logic [CHUNK_W*PARTS-1:0]   in_a,
    input  logic [CHUNK_W*PARTS-1:0]   in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHUNK_W*PARTS-1:0]   out_result
);

    localparam int unsigned XLEN  = CHUNK_W * PARTS;
    localparam int unsigned SH_W  = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int unsigned WSH_W = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
    localparam int unsigned IDX_W = (PARTS > 1) ? $clog2(PARTS) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q;
    logic                word_q;
    logic [XLEN-1:0]     a_q, b_q, result_q;
    logic [IDX_W-1:0]    idx_q, idx_next, start_idx;
    logic                carry_q, lt_q, eq_q;

    logic                in_word_eff;
    logic                msb_first, last_chunk;
    int                  n_parts, j, k, r;
    logic [SH_W-1:0]     sh;
    logic                sign;
    logic [CHUNK_W-1:0]  a_i, b_i, fill_sel, chunk_res;
    logic [2*CHUNK_W-1:0] funnel;
    logic [CHUNK_W:0]    sum;
    logic                cmp_lt, carry_d, lt_d, eq_d;

    // Compares and right shifts must see the high chunks first
    function automatic logic is_msb_first(input logic [3:0] op);
        return (op == OP_SLT) || (op == OP_SLTU) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Chunk j of v; chunks outside 0..n-1 read as the supplied fill
    function automatic logic [CHUNK_W-1:0] chunk_of(input logic [XLEN-1:0] v, input int jj,
                                                    input int n, input logic [CHUNK_W-1:0] fill);
        if (jj < 0 || jj >= n) return fill;
        return v[jj*CHUNK_W +: CHUNK_W];
    endfunction

    assign in_word_eff = in_word && (PARTS > 1);
    assign start_idx   = (is_msb_first(in_op) && !in_word_eff) ? IDX_W'(PARTS - 1) : '0;

    // One chunk of the selected operation
    always_comb begin
        chunk_res = '0;
        carry_d   = carry_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        funnel    = '0;
        sum       = '0;
        fill_sel  = '0;
        n_parts   = word_q ? 1 : int'(PARTS);
        j         = int'(idx_q);
        sh        = word_q ? SH_W'(b_q[WSH_W-1:0]) : b_q[SH_W-1:0];
        k         = int'(sh) / int'(CHUNK_W);
        r         = int'(sh) % int'(CHUNK_W);
        sign      = word_q ? a_q[CHUNK_W-1] : a_q[XLEN-1];
        a_i       = chunk_of(a_q, j, n_parts, '0);
        b_i       = chunk_of(b_q, j, n_parts, '0);
        cmp_lt    = (op_q == OP_SLT && j == n_parts - 1) ? ($signed(a_i) < $signed(b_i))
                                                         : (a_i < b_i);
        msb_first = is_msb_first(op_q);
        last_chunk = msb_first ? (idx_q == '0) : (j == n_parts - 1);
        idx_next  = msb_first ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);

        case (op_q)
            OP_ADD, OP_SUB: begin
                sum = {1'b0, a_i} + {1'b0, (op_q == OP_SUB) ? ~b_i : b_i}
                    + {{CHUNK_W{1'b0}}, carry_q};
                chunk_res = sum[CHUNK_W-1:0];
                carry_d   = sum[CHUNK_W];
            end
            OP_SLL: begin
                funnel = {chunk_of(a_q, j - k, n_parts, '0),
                          chunk_of(a_q, j - k - 1, n_parts, '0)} << r;
                chunk_res = funnel[2*CHUNK_W-1:CHUNK_W];
            end
            OP_SRL, OP_SRA: begin
                fill_sel = (op_q == OP_SRA) ? {CHUNK_W{sign}} : '0;
                funnel = {chunk_of(a_q, j + k + 1, n_parts, fill_sel),
                          chunk_of(a_q, j + k, n_parts, fill_sel)} >> r;
                chunk_res = funnel[CHUNK_W-1:0];
            end
            OP_SLT, OP_SLTU: begin
                if (eq_q && (a_i != b_i)) begin
                    lt_d = cmp_lt;
                    eq_d = 1'b0;
                end
                chunk_res = (j == 0) ? {{(CHUNK_W-1){1'b0}}, lt_d} : '0;
            end
            OP_XOR:  chunk_res = a_i ^ b_i;
            OP_OR:   chunk_res = a_i | b_i;
            OP_AND:  chunk_res = a_i & b_i;
            default: chunk_res = '0;
        endcase
    end

    // Next-state logic; flush overrides everything including an accept
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid)   state_d = S_EXEC;
                S_EXEC:  if (last_chunk) state_d = S_DONE;
                S_DONE:  if (out_ready)  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            word_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        word_q  <= in_word_eff;
                        a_q     <= in_a;
                        b_q     <= in_b;
                        idx_q   <= start_idx;
                        carry_q <= (in_op == OP_SUB);
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    carry_q <= carry_d;
                    lt_q    <= lt_d;
                    eq_q    <= eq_d;
                    idx_q   <= idx_next;
                    // Word ops write chunk 0 and sign-extend it across the upper chunks
                    for (int p = 0; p < int'(PARTS); p++) begin
                        if (word_q)
                            result_q[p*CHUNK_W +: CHUNK_W] <= (p == 0) ? chunk_res
                                                            : {CHUNK_W{chunk_res[CHUNK_W-1]}};
                        else if (p == j)
                            result_q[p*CHUNK_W +: CHUNK_W] <= chunk_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_result = result_q;

endmodule

// File: tb/tb_clarvi_chunked_alu.sv
// Bench for clarvi_chunked_alu: a 32x2 and a 16x4 instance checked against a 64-bit arithmetic model.
module tb_clarvi_chunked_alu;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_v     [2];
    logic        in_valid_v  [2];
    logic        out_ready_v [2];
    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    logic [63:0] out_result_v[2];
    logic [3:0]  in_op;
    logic        in_word;
    logic [63:0] in_a, in_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    clarvi_chunked_alu #(.CHUNK_W(32), .PARTS(2)) dut_p2 (
        .clock(clock), .reset(reset), .flush(flush_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_result(out_result_v[0])
    );

    clarvi_chunked_alu #(.CHUNK_W(16), .PARTS(4)) dut_p4 (
        .clock(clock), .reset(reset), .flush(flush_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_result(out_result_v[1])
    );

    function automatic int cw_of(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic int parts_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] v, input int cw);
        logic [63:0] m;
        m = (64'd1 << cw) - 64'd1;
        if (v[cw-1]) return v | ~m;
        return v & m;
    endfunction

    // Whole-operand reference: plain 64-bit arithmetic, word ops truncated and sign-extended
    function automatic logic [63:0] model(input logic [3:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b, input int cw);
        logic [63:0] r, m, aw, bw;
        int sh;
        r = '0;
        if (!w) begin
            sh = int'(b[5:0]);
            case (op)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a << sh;
                4'd3: r = {63'd0, ($signed(a) < $signed(b))};
                4'd4: r = {63'd0, (a < b)};
                4'd5: r = a ^ b;
                4'd6: r = a >> sh;
                4'd7: r = $signed(a) >>> sh;
                4'd8: r = a | b;
                4'd9: r = a & b;
                default: r = '0;
            endcase
            return r;
        end
        m  = (64'd1 << cw) - 64'd1;
        aw = sext(a & m, cw);
        bw = sext(b & m, cw);
        sh = int'(b[5:0]) % cw;
        case (op)
            4'd0: r = aw + bw;
            4'd1: r = aw - bw;
            4'd2: r = (a & m) << sh;
            4'd3: r = {63'd0, ($signed(aw) < $signed(bw))};
            4'd4: r = {63'd0, ((a & m) < (b & m))};
            4'd5: r = aw ^ bw;
            4'd6: r = (a & m) >> sh;
            4'd7: r = $signed(aw) >>> sh;
            4'd8: r = aw | bw;
            4'd9: r = aw & bw;
            default: r = '0;
        endcase
        return sext(r & m, cw);
    endfunction

    // Issue one request, count edges until out_valid (bounded), then consume the result
    task automatic run_op(input int d, input logic [3:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        @(negedge clock);
        in_op = op; in_word = w; in_a = a; in_b = b;
        in_valid_v[d] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[d] = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_op = 4'($urandom);
        in_word = ~w;
        lat = 0;
        while (out_valid_v[d] !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        res = out_result_v[d];
        @(negedge clock);
        out_ready_v[d] = 1'b1;
        @(posedge clock); #1;
        out_ready_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (in_ready_v[d] !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready_v[d]);
            end
            tests_run++;
            if (out_valid_v[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid_v[d]);
            end
            tests_run++;
            if (out_result_v[d] !== 64'd0) begin
                tests_failed++;
                $display("FAIL reset_out_result[%0d]: got %h want 0", d, out_result_v[d]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_idle[%0d]: got ready=%b valid=%b want 1/0",
                         d, in_ready_v[d], out_valid_v[d]);
            end
        end
    endtask

    typedef struct {
        int          d;
        logic [3:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [16];
        logic [63:0] res;
        int lat;
        vecs = '{
            '{0, 4'd0, 1'b0, 64'h00000000_FFFFFFFF, 64'd1, 64'h00000001_00000000, 2},
            '{0, 4'd0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'h0, 2},
            '{0, 4'd3, 1'b0, 64'hFFFFFFFF_00000000, 64'd1, 64'd1, 2},
            '{0, 4'd4, 1'b0, 64'hFFFFFFFF_00000000, 64'd1, 64'd0, 2},
            '{0, 4'd3, 1'b0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'd0, 2},
            '{0, 4'd4, 1'b0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'd0, 2},
            '{1, 4'd7, 1'b0, 64'h8000_0000_0000_1234, 64'd20, 64'hFFFF_F800_0000_0000, 4},
            '{1, 4'd2, 1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4},
            '{1, 4'd6, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'hDEAD_BEEF_0123_4567, 4},
            '{0, 4'd0, 1'b1, 64'h00000000_7FFFFFFF, 64'd1, 64'hFFFFFFFF_80000000, 1},
            '{1, 4'd1, 1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4},
            '{1, 4'd12, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'd0, 4},
            '{1, 4'd7, 1'b1, 64'h0000_0000_0000_8000, 64'd4, 64'hFFFF_FFFF_FFFF_F800, 1},
            '{0, 4'd3, 1'b1, 64'h00000001_80000000, 64'hFFFFFFFF_00000001, 64'd1, 1},
            '{1, 4'd4, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h0001_0000_0000_0000, 64'd1, 4},
            '{1, 4'd3, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 4}
        };
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].d, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
            tests_run++;
            if (res !== vecs[i].exp) begin
                tests_failed++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, vecs[i].exp);
            end
            tests_run++;
            if (lat != vecs[i].lat) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, vecs[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, exp;
        logic [3:0]  op;
        logic        w;
        int d, lat, exp_lat;
        for (int i = 0; i < 160; i++) begin
            d  = i % 2;
            op = 4'($urandom_range(0, 15));
            w  = ($urandom_range(0, 3) == 0);
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       b = a;
                1:       b = a ^ (64'd1 << $urandom_range(0, 63));
                2:       b = 64'($urandom_range(0, 70));
                default: b = {$urandom, $urandom};
            endcase
            exp     = model(op, w, a, b, cw_of(d));
            exp_lat = w ? 1 : parts_of(d);
            run_op(d, op, w, a, b, res, lat);
            tests_run++;
            if (res !== exp) begin
                tests_failed++;
                $display("FAIL random_result[%0d] d=%0d op=%0d w=%b a=%h b=%h: got %h want %h",
                         i, d, op, w, a, b, res, exp);
            end
            tests_run++;
            if (lat != exp_lat) begin
                tests_failed++;
                $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a1, b1, a2, b2, exp1;
        int lat;
        a1 = 64'h0123_4567_89AB_CDEF;
        b1 = 64'h1111_1111_F000_0000;
        a2 = 64'hA5A5_A5A5_0F0F_0F0F;
        b2 = 64'h5A5A_0000_FFFF_1234;
        exp1 = model(4'd0, 1'b0, a1, b1, 32);
        @(negedge clock);
        in_op = 4'd0; in_word = 1'b0; in_a = a1; in_b = b1;
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        tests_run++;
        if (lat != 2) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d want 2", lat);
        end
        @(negedge clock);
        in_op = 4'd5; in_a = a2; in_b = b2;
        in_valid_v[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            tests_run++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || out_result_v[0] !== exp1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h want 1/0/%h",
                         c, out_valid_v[0], in_ready_v[0], out_result_v[0], exp1);
            end
        end
        @(negedge clock);
        out_ready_v[0] = 1'b1;
        @(posedge clock); #1;
        out_ready_v[0] = 1'b0;
        tests_run++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
        end
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        tests_run++;
        if (lat != 2 || out_result_v[0] !== (a2 ^ b2)) begin
            tests_failed++;
            $display("FAIL bp_next_op: got lat=%0d res=%h want 2/%h", lat, out_result_v[0], a2 ^ b2);
        end
        @(negedge clock);
        out_ready_v[0] = 1'b1;
        @(posedge clock); #1;
        out_ready_v[0] = 1'b0;
    endtask

    task automatic test_flush();
        logic [63:0] res, exp;
        int lat;
        bit seen;
        // Flush in the second EXEC cycle of the two-chunk instance
        @(negedge clock);
        in_op = 4'd0; in_word = 1'b0; in_a = 64'h0000_0001_FFFF_FFFF; in_b = 64'd7;
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        flush_v[0] = 1'b1;
        @(posedge clock); #1;
        flush_v[0] = 1'b0;
        tests_run++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_exec: got valid=%b ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (out_valid_v[0] === 1'b1) seen = 1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL flush_exec_no_result: got out_valid=1 want 0");
        end
        // A request presented together with flush in IDLE must not be accepted
        @(negedge clock);
        in_valid_v[0] = 1'b1;
        flush_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        flush_v[0] = 1'b0;
        tests_run++;
        if (in_ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle_accept: got in_ready=%b want 1", in_ready_v[0]);
        end
        seen = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (out_valid_v[0] === 1'b1) seen = 1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL flush_idle_no_result: got out_valid=1 want 0");
        end
        // Flush an unconsumed result on the four-chunk instance
        @(negedge clock);
        in_op = 4'd8; in_word = 1'b0; in_a = 64'h00F0_0000_0000_000F; in_b = 64'h0F00_0000_0000_00F0;
        in_valid_v[1] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[1] = 1'b0;
        lat = 0;
        while (out_valid_v[1] !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        @(negedge clock);
        flush_v[1] = 1'b1;
        @(posedge clock); #1;
        flush_v[1] = 1'b0;
        tests_run++;
        if (lat != 4 || out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_done: got lat=%0d valid=%b ready=%b want 4/0/1",
                     lat, out_valid_v[1], in_ready_v[1]);
        end
        exp = model(4'd1, 1'b0, 64'h0000_0000_0001_0000, 64'd1, 32);
        run_op(0, 4'd1, 1'b0, 64'h0000_0000_0001_0000, 64'd1, res, lat);
        tests_run++;
        if (res !== exp || lat != 2) begin
            tests_failed++;
            $display("FAIL flush_recover: got res=%h lat=%0d want %h/2", res, lat, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] res, exp;
        int lat;
        bit seen;
        @(negedge clock);
        in_op = 4'd0; in_word = 1'b0;
        in_a = 64'h1234_5678_1234_5678; in_b = 64'h0101_0101_0101_0101;
        in_valid_v[0] = 1'b1;
        in_valid_v[1] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        tests_run++;
        if (out_valid_v[0] !== 1'b1 || out_valid_v[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_setup: got valid0=%b valid1=%b want 1/0", out_valid_v[0], out_valid_v[1]);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid_v[0] !== 1'b0 || out_result_v[0] !== 64'd0 || in_ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_done: got valid=%b res=%h ready=%b want 0/0/1",
                     out_valid_v[0], out_result_v[0], in_ready_v[0]);
        end
        tests_run++;
        if (out_valid_v[1] !== 1'b0 || out_result_v[1] !== 64'd0 || in_ready_v[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_exec: got valid=%b res=%h ready=%b want 0/0/1",
                     out_valid_v[1], out_result_v[1], in_ready_v[1]);
        end
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (out_valid_v[0] === 1'b1 || out_valid_v[1] === 1'b1) seen = 1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL areset_no_result: got out_valid=1 want 0");
        end
        exp = model(4'd9, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_F0F0_F0F0_F0F0, 16);
        run_op(1, 4'd9, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_F0F0_F0F0_F0F0, res, lat);
        tests_run++;
        if (res !== exp || lat != 4) begin
            tests_failed++;
            $display("FAIL areset_recover: got res=%h lat=%0d want %h/4", res, lat, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_op = '0; in_word = 1'b0; in_a = '0; in_b = '0;
        for (int d = 0; d < 2; d++) begin
            flush_v[d]     = 1'b0;
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b0;
        end
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
